// File: rtl/ext_seg_scan_ctrl.sv
// Multiplexed 4-digit segment display scanner with guard blanking, per-digit
// blank/blink and frame-synchronous loading of display content.
//
// state | meaning
// OFF   | display dark, counters cleared, staged loads apply immediately
// SCAN  | one digit driven for REFRESH_DIV cycles
// GUARD | all anodes off for GUARD_CYC cycles before the next digit
module ext_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYC    = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_N,
  input  logic        enable_In,
  input  logic [15:0] digits_In,
  input  logic [3:0]  blank_In,
  input  logic [3:0]  blink_In,
  input  logic        load_In,
  output logic        load_Ack,
  output logic [3:0]  bcd_Out,
  output logic        display_On,
  output logic [3:0]  anode_Out,
  output logic        frame_Tick
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {OFF, SCAN, GUARD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_ph, blink_ph_nx;
  logic          pending;
  logic [15:0]   stg_digits, act_digits, act_digits_nx;
  logic [3:0]    stg_blank, stg_blink, act_blank, act_blink;
  logic [3:0]    act_blank_nx, act_blink_nx;
  logic          boundary, apply, apply_go;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    idx_nx       = idx;
    blink_cnt_nx = blink_cnt;
    blink_ph_nx  = blink_ph;
    boundary     = 1'b0;
    case (state)
      SCAN: begin
        if (!enable_In) begin
          state_nx = OFF;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
          state_nx = GUARD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      GUARD: begin
        if (!enable_In) begin
          state_nx = OFF;
        end else if (cnt == CW'(GUARD_CYC - 1)) begin
          state_nx = SCAN;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          if (idx == 2'd3) begin
            boundary = 1'b1;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt_nx = '0;
              blink_ph_nx  = ~blink_ph;
            end else begin
              blink_cnt_nx = blink_cnt + BW'(1);
            end
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        if (enable_In) state_nx = SCAN;
      end
    endcase
    // Leaving SCAN/GUARD for OFF lands with everything already cleared.
    if (state_nx == OFF) begin
      cnt_nx       = '0;
      idx_nx       = '0;
      blink_cnt_nx = '0;
      blink_ph_nx  = 1'b0;
    end
  end

  always_comb begin
    apply         = (state == OFF) || boundary;
    apply_go      = apply && (load_In || pending);
    act_digits_nx = act_digits;
    act_blank_nx  = act_blank;
    act_blink_nx  = act_blink;
    if (apply && load_In) begin
      act_digits_nx = digits_In;
      act_blank_nx  = blank_In;
      act_blink_nx  = blink_In;
    end else if (apply && pending) begin
      act_digits_nx = stg_digits;
      act_blank_nx  = stg_blank;
      act_blink_nx  = stg_blink;
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state      <= OFF;
      cnt        <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      pending    <= 1'b0;
      stg_digits <= '0;
      stg_blank  <= '0;
      stg_blink  <= '0;
      act_digits <= '0;
      act_blank  <= '0;
      act_blink  <= '0;
      load_Ack   <= 1'b0;
      frame_Tick <= 1'b0;
      anode_Out  <= 4'b1111;
      bcd_Out    <= '0;
      display_On <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      blink_cnt  <= blink_cnt_nx;
      blink_ph   <= blink_ph_nx;
      act_digits <= act_digits_nx;
      act_blank  <= act_blank_nx;
      act_blink  <= act_blink_nx;
      load_Ack   <= apply_go;
      frame_Tick <= boundary;
      if (apply) begin
        pending <= 1'b0;
      end else if (load_In) begin
        pending    <= 1'b1;
        stg_digits <= digits_In;
        stg_blank  <= blank_In;
        stg_blink  <= blink_In;
      end
      if (state_nx == SCAN) begin
        anode_Out  <= ~(4'b0001 << idx_nx);
        bcd_Out    <= act_digits_nx[{idx_nx, 2'b00} +: 4];
        display_On <= ~act_blank_nx[idx_nx] & ~(act_blink_nx[idx_nx] & blink_ph_nx);
      end else begin
        anode_Out  <= 4'b1111;
        bcd_Out    <= '0;
        display_On <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ext_seg_scan_ctrl.sv
// Directed bench for ext_seg_scan_ctrl: scan order, frame-synchronous loads,
// blink/blank, enable drop and mid-guard reset.
module tb_ext_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_N;
  logic        enable_In;
  logic [15:0] digits_In;
  logic [3:0]  blank_In;
  logic [3:0]  blink_In;
  logic        load_In;
  logic        load_Ack;
  logic [3:0]  bcd_Out;
  logic        display_On;
  logic [3:0]  anode_Out;
  logic        frame_Tick;

  int checks   = 0;
  int failures = 0;

  ext_seg_scan_ctrl #(
    .REFRESH_DIV (4),
    .GUARD_CYC   (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_N     (rst_N),
    .enable_In (enable_In),
    .digits_In (digits_In),
    .blank_In  (blank_In),
    .blink_In  (blink_In),
    .load_In   (load_In),
    .load_Ack  (load_Ack),
    .bcd_Out   (bcd_Out),
    .display_On(display_On),
    .anode_Out (anode_Out),
    .frame_Tick(frame_Tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " anode"}, 32'(anode_Out), 32'hF);
    chk({tag, " disp"}, 32'(display_On), 32'h0);
    chk({tag, " bcd"}, 32'(bcd_Out), 32'h0);
  endtask

  // One 20-cycle frame starting at its first SCAN cycle; optional loads injected.
  task automatic run_frame(input int fid, input logic [15:0] dig, input logic [3:0] blk,
                           input logic [3:0] bli, input logic ph, input logic tick0,
                           input logic ack0, input int ld_c, input int ld_n,
                           input logic [15:0] ld_a, input logic [15:0] ld_b);
    for (int c = 0; c < 20; c++) begin
      int k;
      int pos;
      string t;
      k   = c / 5;
      pos = c % 5;
      t   = $sformatf("f%0d c%0d", fid, c);
      if (pos < 4) begin
        chk({t, " anode"}, 32'(anode_Out), 32'(~(4'b0001 << k) & 4'hF));
        chk({t, " bcd"}, 32'(bcd_Out), 32'((dig >> (4 * k)) & 16'hF));
        chk({t, " disp"}, 32'(display_On), 32'(!blk[k] && !(bli[k] && ph)));
      end else begin
        chk({t, " anode"}, 32'(anode_Out), 32'hF);
        chk({t, " disp"}, 32'(display_On), 32'h0);
      end
      chk({t, " tick"}, 32'(frame_Tick), (c == 0) ? 32'(tick0) : 32'h0);
      chk({t, " ack"}, 32'(load_Ack), (c == 0) ? 32'(ack0) : 32'h0);
      if (c == ld_c) begin
        load_In   = 1'b1;
        digits_In = ld_a;
      end else if (ld_n == 2 && c == ld_c + 1) begin
        load_In   = 1'b1;
        digits_In = ld_b;
      end else begin
        load_In = 1'b0;
      end
      tick();
    end
    load_In = 1'b0;
  endtask

  initial begin
    rst_N     = 1'b0;
    enable_In = 1'b0;
    digits_In = '0;
    blank_In  = '0;
    blink_In  = '0;
    load_In   = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset ack", 32'(load_Ack), 32'h0);
    chk("reset tick", 32'(frame_Tick), 32'h0);
    rst_N = 1'b1;
    tick();

    // load while OFF applies at once
    load_In   = 1'b1;
    digits_In = 16'h4321;
    tick();
    load_In = 1'b0;
    chk("off load ack", 32'(load_Ack), 32'h1);
    chk_idle("off");
    tick();
    chk("off ack once", 32'(load_Ack), 32'h0);
    enable_In = 1'b1;
    tick();

    // F1: 4321, load ABCD mid digit 1 -> staged until boundary
    run_frame(1, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 6, 1, 16'hABCD, 16'h0);
    // F2: ABCD; load 5678 with blank/blink on the boundary cycle
    blank_In = 4'b1000;
    blink_In = 4'b0001;
    run_frame(2, 16'hABCD, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 19, 1, 16'h5678, 16'h0);
    // F3: phase now 1; back-to-back loads, last wins
    run_frame(3, 16'h5678, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b1, 3, 2, 16'h1111, 16'h9ABC);
    run_frame(4, 16'h9ABC, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b1, -1, 0, 16'h0, 16'h0);
    run_frame(5, 16'h9ABC, 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0, -1, 0, 16'h0, 16'h0);
    run_frame(6, 16'h9ABC, 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0, -1, 0, 16'h0, 16'h0);
    run_frame(7, 16'h9ABC, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, -1, 0, 16'h0, 16'h0);

    // enable drop mid-SCAN with a pending load
    tick();
    tick();
    blank_In  = 4'h0;
    blink_In  = 4'h0;
    load_In   = 1'b1;
    digits_In = 16'h0F0E;
    tick();
    load_In   = 1'b0;
    enable_In = 1'b0;
    chk("pend no ack", 32'(load_Ack), 32'h0);
    tick();
    chk_idle("drop");
    chk("drop ack", 32'(load_Ack), 32'h0);
    tick();
    chk("drop apply ack", 32'(load_Ack), 32'h1);
    chk_idle("drop off");
    tick();
    chk("drop ack once", 32'(load_Ack), 32'h0);
    enable_In = 1'b1;
    tick();
    run_frame(8, 16'h0F0E, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 16'h0, 16'h0);

    // reset mid-GUARD with a load pending
    tick();
    tick();
    load_In   = 1'b1;
    digits_In = 16'h7777;
    tick();
    load_In = 1'b0;
    tick();
    chk("guard anode", 32'(anode_Out), 32'hF);
    #1 rst_N = 1'b0;
    #1;
    chk_idle("async rst");
    chk("async rst ack", 32'(load_Ack), 32'h0);
    chk("async rst tick", 32'(frame_Tick), 32'h0);
    enable_In = 1'b0;
    tick();
    tick();
    chk("rst hold ack", 32'(load_Ack), 32'h0);
    rst_N = 1'b1;
    tick();
    chk("post rst ack", 32'(load_Ack), 32'h0);
    chk_idle("post rst");
    enable_In = 1'b1;
    tick();
    run_frame(9, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 16'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_seg_scan_ctrl.md
EXT_SEG_SCAN_CTRL -- requirements
Module: ext_seg_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clk cycles each digit is driven per scan slot (minimum 2).
REQ-002 Parameter: GUARD_CYC, default 4, anti-ghosting blank cycles between digits (minimum 1).
REQ-003 Parameter: BLINK_FRAMES, default 64, frames per blink half-period (minimum 1).
REQ-004 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst_N  in  1  asynchronous, active-low reset.
REQ-006 Port: enable_In  in  1  global display enable.
REQ-007 Port: digits_In  in  16  four hex nibbles; digit k = [4k+3:4k].
REQ-008 Port: blank_In  in  4  per-digit force-off; bit k = digit k.
REQ-009 Port: blink_In  in  4  per-digit blink enable.
REQ-010 Port: load_In  in  1  one-cycle request to capture digits_In, blank_In and blink_In.
REQ-011 Port: load_Ack  out  1  one-cycle pulse when captured values become active.
REQ-012 Port: bcd_Out  out  4  nibble for the external segment decoder.
REQ-013 Port: display_On  out  1  decoder enable.
REQ-014 Port: anode_Out  out  4  active-low one-hot digit select; 4'b1111 = none.
REQ-015 Port: frame_Tick  out  1  one-cycle pulse at each completed 4-digit frame.

Function
REQ-016 FSM states are OFF, SCAN and GUARD; all outputs are registered.
REQ-017 OFF: anode_Out=4'b1111, display_On=0, bcd_Out=0, slot counter=0, digit index=0, blink counter=0, blink phase=0.
REQ-018 OFF->SCAN when enable_In=1; the first SCAN cycle drives digit 0.
REQ-019 Any state->OFF on the cycle after enable_In=0 is sampled; a scan in progress is abandoned.
REQ-020 SCAN: anode_Out bit[idx]=0, bcd_Out=active digit[idx], counter increments each cycle; at REFRESH_DIV-1 -> GUARD with counter=0.
REQ-021 GUARD: anode_Out=4'b1111, display_On=0; after GUARD_CYC cycles idx<=idx+1 mod 4 -> SCAN.
REQ-022 Leaving GUARD with idx=3 (wrap to 0) is the frame boundary; frame_Tick=1 on the first following SCAN cycle.
REQ-023 SCAN display_On = NOT(blank[idx]) AND NOT(blink[idx] AND blink phase).
REQ-024 Blink frame counter counts frame boundaries; at BLINK_FRAMES it toggles blink phase and clears.
REQ-025 load_In=1 copies inputs to a staging register and sets pending; a repeat load while pending overwrites staging and produces one ack only.
REQ-026 Staging -> active only at a frame boundary, or on any cycle in OFF; load_Ack=1 on the following cycle; pending clears.
REQ-027 load_In coinciding with an apply cycle: digits_In bypasses staging into active, one ack, pending=0.
REQ-028 Active values never change mid-frame while in SCAN/GUARD (no torn frames).

Reset
REQ-029 rst_N=0 asynchronously forces: state=OFF, anode_Out=4'b1111, bcd_Out=0, display_On=0, load_Ack=0, frame_Tick=0.
REQ-030 Reset also clears staging, active, pending, counters, index and blink phase to 0.
REQ-031 After release, the first state change is the OFF->SCAN transition of REQ-018; rst_N mid-frame aborts the frame with no ack.

Verification (bench uses REFRESH_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2)
REQ-032 Enable, load 16'h4321 with no blank/blink -> anode sequence 1110,1111,1101,1111,1011,1111,0111,1111; digit slots 4 cycles, guard slots 1 cycle; bcd 1,2,3,4; frame_Tick every 20 cycles.
REQ-033 Load 16'hABCD mid-digit-1 -> active stays 4321 until the frame boundary; load_Ack exactly once, one cycle after apply; next frame shows D,C,B,A.
REQ-034 blink_In=4'b0001 -> digit 0 display_On=0 for 2 frames, then 1 for 2 frames; other digits always on; blank_In=4'b1000 -> digit 3 display_On=0 always.
REQ-035 enable_In=0 mid-SCAN -> next cycle anode_Out=1111; a pending load applies in OFF and ack is seen; re-enable resumes at digit 0.
REQ-036 Assert rst_N=0 mid-GUARD with a load pending -> outputs at reset values immediately, no load_Ack, active=0 after release.
REQ-037 load_In on the frame-boundary cycle -> new digits shown from the next frame's digit 0 and exactly one ack; back-to-back loads -> last value wins with one ack.
